// File: rtl/apb_capture_timer_pkg.sv
// Shared register map, bit positions and FSM encoding for apb_capture_timer.
package apb_capture_timer_pkg;

  // Byte offsets of the APB registers
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_PERIOD = 4'h8;
  localparam logic [3:0] OFF_HIGH   = 4'hC;

  // Word index as decoded from paddr[3:2]
  localparam logic [1:0] IDX_CTRL   = OFF_CTRL[3:2];
  localparam logic [1:0] IDX_STATUS = OFF_STATUS[3:2];
  localparam logic [1:0] IDX_PERIOD = OFF_PERIOD[3:2];
  localparam logic [1:0] IDX_HIGH   = OFF_HIGH[3:2];

  // CTRL bits
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;

  // STATUS bits (write-one-to-clear)
  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_OVR_BIT   = 1;
  localparam int STAT_OVF_BIT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/apb_capture_timer_cap_sync_edge.sv
// cap_sync_edge: two-flop synchronizer plus history flop, giving one-cycle
// rise/fall pulses two edges after the input changes.
module cap_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  // Synchronize the asynchronous input and keep one cycle of history
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/apb_capture_timer.sv
// apb_capture_timer: measures period and high time of an external pulse
// and exposes them through a four-register APB slave.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for the first rising edge (or disabled / after OVF)
//   ST_HIGH | input high, counting; fall latches the pending high time
//   ST_LOW  | input low, counting; rise completes the capture
//
// The high time is held in a pending register and only committed to HIGH
// together with PERIOD, so an overflow, disable or reset part-way through a
// measurement never leaves a half-updated PERIOD/HIGH pair.
module apb_capture_timer
  import apb_capture_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        apb_pclk,
  input  logic        apb_prstn,
  input  logic        apb_psel,
  input  logic [3:0]  apb_paddr,
  input  logic        apb_pwrite,
  input  logic        apb_penable,
  input  logic [31:0] apb_pwdata,
  output logic [31:0] apb_prdata,
  input  logic        cap_in,
  output logic        cap_int
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             rise, fall;
  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_pend_q, high_pend_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             ctrl_en_q, ctrl_en_d;
  logic             ctrl_ie_q, ctrl_ie_d;
  logic             en_arm_q, en_arm_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ovf_q, ovf_d;
  logic             cap_int_q, cap_int_d;
  logic             cap_done, ovf_hit;
  logic             wr_en;
  logic [1:0]       reg_idx;
  logic [2:0]       w1c;
  logic             unused_ok;

  assign unused_ok = ^{apb_paddr[1:0], apb_pwdata[31:3]};
  assign wr_en     = apb_psel & apb_penable & apb_pwrite;
  assign reg_idx   = apb_paddr[3:2];
  assign cap_int   = cap_int_q;

  cap_sync_edge u_sync (
    .clk      (apb_pclk),
    .rstn     (apb_prstn),
    .async_in (cap_in),
    .rise     (rise),
    .fall     (fall)
  );

  // FSM state, running counter and pending high time
  always_ff @(posedge apb_pclk) begin
    if (!apb_prstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      high_pend_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_pend_q <= high_pend_d;
    end
  end

  // Next-state logic; saturation is checked before edges so cnt never wraps.
  // en_arm_q delays arming by one cycle so a rise coinciding with EN turning
  // on cannot start a capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_pend_d = high_pend_q;
    cap_done    = 1'b0;
    ovf_hit     = 1'b0;
    if (!ctrl_en_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise && en_arm_q) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_q == CNT_MAX) begin
            ovf_hit = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (fall) begin
              high_pend_d = cnt_q;
              state_d     = ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (cnt_q == CNT_MAX) begin
            ovf_hit = 1'b1;
            state_d = ST_IDLE;
          end else if (rise) begin
            cap_done = 1'b1;
            cnt_d    = CNT_ONE;
            state_d  = ST_HIGH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Register-file updates; a hardware set beats a same-cycle W1C
  always_comb begin
    ctrl_en_d = ctrl_en_q;
    ctrl_ie_d = ctrl_ie_q;
    w1c       = '0;
    if (wr_en && reg_idx == IDX_CTRL) begin
      ctrl_en_d = apb_pwdata[CTRL_EN_BIT];
      ctrl_ie_d = apb_pwdata[CTRL_IE_BIT];
    end
    if (wr_en && reg_idx == IDX_STATUS) begin
      w1c = apb_pwdata[2:0];
    end
    valid_d   = (valid_q & ~w1c[STAT_VALID_BIT]) | cap_done;
    ovr_d     = (ovr_q & ~w1c[STAT_OVR_BIT]) | (cap_done & valid_q);
    ovf_d     = (ovf_q & ~w1c[STAT_OVF_BIT]) | ovf_hit;
    period_d  = cap_done ? cnt_q : period_q;
    high_d    = cap_done ? high_pend_q : high_q;
    cap_int_d = ctrl_ie_q & (valid_q | ovf_q);
    en_arm_d  = ctrl_en_q;
  end

  // Register-file and interrupt flops
  always_ff @(posedge apb_pclk) begin
    if (!apb_prstn) begin
      ctrl_en_q <= 1'b0;
      ctrl_ie_q <= 1'b0;
      en_arm_q  <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ovf_q     <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      cap_int_q <= 1'b0;
    end else begin
      ctrl_en_q <= ctrl_en_d;
      ctrl_ie_q <= ctrl_ie_d;
      en_arm_q  <= en_arm_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ovf_q     <= ovf_d;
      period_q  <= period_d;
      high_q    <= high_d;
      cap_int_q <= cap_int_d;
    end
  end

  // Zero-wait-state read mux, driven only during a read select
  always_comb begin
    apb_prdata = '0;
    if (apb_psel && !apb_pwrite) begin
      case (reg_idx)
        IDX_CTRL: begin
          apb_prdata[CTRL_EN_BIT] = ctrl_en_q;
          apb_prdata[CTRL_IE_BIT] = ctrl_ie_q;
        end
        IDX_STATUS: begin
          apb_prdata[STAT_VALID_BIT] = valid_q;
          apb_prdata[STAT_OVR_BIT]   = ovr_q;
          apb_prdata[STAT_OVF_BIT]   = ovf_q;
        end
        IDX_PERIOD: apb_prdata = 32'(period_q);
        IDX_HIGH:   apb_prdata = 32'(high_q);
        default:    apb_prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_capture_timer.sv
// Directed bench for apb_capture_timer: a 32-bit instance for the main
// capture scenarios and an 8-bit instance for counter saturation.
module tb_apb_capture_timer;
  import apb_capture_timer_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel = 1'b0;
  logic        pwrite = 1'b0;
  logic        penable = 1'b0;
  logic [3:0]  paddr = 4'h0;
  logic [31:0] pwdata = 32'h0;
  logic        cap_in = 1'b0;
  logic        cap_in8 = 1'b0;
  logic [31:0] prdata, prdata8;
  logic        cap_int, cap_int8;
  logic [31:0] rd, rd8;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  apb_capture_timer #(.CNT_W(32)) u_dut (
    .apb_pclk    (clk),
    .apb_prstn   (rstn),
    .apb_psel    (psel),
    .apb_paddr   (paddr),
    .apb_pwrite  (pwrite),
    .apb_penable (penable),
    .apb_pwdata  (pwdata),
    .apb_prdata  (prdata),
    .cap_in      (cap_in),
    .cap_int     (cap_int)
  );

  apb_capture_timer #(.CNT_W(8)) u_dut8 (
    .apb_pclk    (clk),
    .apb_prstn   (rstn),
    .apb_psel    (psel),
    .apb_paddr   (paddr),
    .apb_pwrite  (pwrite),
    .apb_penable (penable),
    .apb_pwdata  (pwdata),
    .apb_prdata  (prdata8),
    .cap_in      (cap_in8),
    .cap_int     (cap_int8)
  );

  // Advance n rising edges and settle 1 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Setup phase now, access phase after one edge; write lands on the second edge
  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    step(1);
    penable = 1'b1;
    step(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Combinational read, completed well before the next edge
  task automatic apb_read(input logic [3:0] a);
    psel = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    rd  = prdata;
    rd8 = prdata8;
    psel = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_prdata_nosel", prdata, 32'h0);
    chk("rst_cap_int", 32'(cap_int), 32'h0);
    rstn = 1'b1;
    step(1);
    apb_read(OFF_CTRL);   chk("rst_ctrl", rd, 32'h0);
    apb_read(OFF_STATUS); chk("rst_status", rd, 32'h0);
    apb_read(OFF_PERIOD); chk("rst_period", rd, 32'h0);
    apb_read(OFF_HIGH);   chk("rst_high", rd, 32'h0);

    // 5 high / 15 low, EN+IE
    apb_write(OFF_CTRL, 32'h3);
    step(2);
    cap_in = 1'b1; step(5);
    cap_in = 1'b0; step(15);
    apb_read(OFF_STATUS); chk("first_pulse_no_valid", rd, 32'h0);
    cap_in = 1'b1; step(2);
    apb_read(OFF_STATUS); chk("rise_not_yet_consumed", rd, 32'h0);
    step(1);
    apb_read(OFF_STATUS); chk("cap1_status", rd, 32'h1);
    apb_read(OFF_PERIOD); chk("cap1_period", rd, 32'd20);
    apb_read(OFF_HIGH);   chk("cap1_high", rd, 32'd5);
    chk("cap1_int_lag", 32'(cap_int), 32'h0);
    step(1);
    chk("cap1_int", 32'(cap_int), 32'h1);
    step(1);
    cap_in = 1'b0;
    apb_write(OFF_STATUS, 32'h1);
    apb_read(OFF_STATUS); chk("w1c_valid", rd, 32'h0);
    chk("int_after_w1c_edge", 32'(cap_int), 32'h1);
    step(1);
    chk("int_cleared", 32'(cap_int), 32'h0);
    step(12);

    // Recapture with VALID clear, then a 3/7 capture over a set VALID
    cap_in = 1'b1; step(3);
    apb_read(OFF_STATUS); chk("cap2_status", rd, 32'h1);
    apb_read(OFF_PERIOD); chk("cap2_period", rd, 32'd20);
    cap_in = 1'b0; step(7);
    cap_in = 1'b1; step(3);
    apb_read(OFF_STATUS); chk("ovr_status", rd, 32'h3);
    apb_read(OFF_PERIOD); chk("ovr_period", rd, 32'd10);
    apb_read(OFF_HIGH);   chk("ovr_high", rd, 32'd3);

    // W1C of VALID on the exact completing edge of a 4/5 capture
    step(1);
    cap_in = 1'b0; step(5);
    cap_in = 1'b1; step(1);
    apb_write(OFF_STATUS, 32'h1);
    apb_read(OFF_STATUS); chk("set_wins_status", rd, 32'h3);
    apb_read(OFF_PERIOD); chk("set_wins_period", rd, 32'd9);
    apb_read(OFF_HIGH);   chk("set_wins_high", rd, 32'd4);

    // Disable during HIGH, retain results, re-enable and measure 6/8
    apb_write(OFF_CTRL, 32'h2);
    step(1);
    chk("dis_state", 32'(u_dut.state_q), 32'(ST_IDLE));
    chk("dis_cnt", u_dut.cnt_q, 32'h0);
    apb_read(OFF_PERIOD); chk("dis_keep_period", rd, 32'd9);
    apb_read(OFF_HIGH);   chk("dis_keep_high", rd, 32'd4);
    apb_read(OFF_STATUS); chk("dis_keep_status", rd, 32'h3);
    cap_in = 1'b0; step(4);
    apb_write(OFF_CTRL, 32'h3);
    step(4);
    cap_in = 1'b1; step(3);
    chk("reen_state", 32'(u_dut.state_q), 32'(ST_HIGH));
    apb_read(OFF_PERIOD); chk("reen_no_partial", rd, 32'd9);
    step(3);
    cap_in = 1'b0; step(8);
    cap_in = 1'b1; step(3);
    apb_read(OFF_PERIOD); chk("reen_period", rd, 32'd14);
    apb_read(OFF_HIGH);   chk("reen_high", rd, 32'd6);

    // Rise in the cycle EN turns on is ignored; next 2/5 pulse measures
    apb_write(OFF_STATUS, 32'h7);
    apb_write(OFF_CTRL, 32'h2);
    step(2);
    cap_in = 1'b0; step(5);
    cap_in = 1'b1;
    apb_write(OFF_CTRL, 32'h3);
    step(1);
    chk("en_rise_ignored", 32'(u_dut.state_q), 32'(ST_IDLE));
    step(3);
    cap_in = 1'b0; step(6);
    cap_in = 1'b1; step(2);
    cap_in = 1'b0; step(1);
    chk("first_rise_state", 32'(u_dut.state_q), 32'(ST_HIGH));
    chk("first_rise_cnt", u_dut.cnt_q, 32'h1);
    step(4);
    cap_in = 1'b1; step(3);
    apb_read(OFF_PERIOD); chk("after_en_period", rd, 32'd7);
    apb_read(OFF_HIGH);   chk("after_en_high", rd, 32'd2);
    apb_read(OFF_STATUS); chk("after_en_status", rd, 32'h1);

    // One-cycle glitch: edge latency against a 3-flop reference, then 1/6
    cap_in = 1'b0; step(5);
    cap_in = 1'b1; step(1);
    chk("lat_rise_e1", 32'(u_dut.u_sync.rise), 32'h0);
    cap_in = 1'b0; step(1);
    chk("lat_rise_e2", 32'(u_dut.u_sync.rise), 32'h1);
    chk("lat_fall_e2", 32'(u_dut.u_sync.fall), 32'h0);
    step(1);
    chk("lat_rise_e3", 32'(u_dut.u_sync.rise), 32'h0);
    chk("lat_fall_e3", 32'(u_dut.u_sync.fall), 32'h1);
    step(1);
    chk("lat_fall_e4", 32'(u_dut.u_sync.fall), 32'h0);
    step(3);
    cap_in = 1'b1; step(3);
    apb_read(OFF_PERIOD); chk("glitch_period", rd, 32'd7);
    apb_read(OFF_HIGH);   chk("glitch_high", rd, 32'd1);

    // Reset in the middle of LOW
    cap_in = 1'b0; step(6);
    chk("pre_rst_state", 32'(u_dut.state_q), 32'(ST_LOW));
    rstn = 1'b0; step(1);
    rstn = 1'b1;
    chk("mid_rst_prdata_nosel", prdata, 32'h0);
    chk("mid_rst_state", 32'(u_dut.state_q), 32'(ST_IDLE));
    chk("mid_rst_cnt", u_dut.cnt_q, 32'h0);
    chk("mid_rst_int", 32'(cap_int), 32'h0);
    apb_read(OFF_CTRL);   chk("mid_rst_ctrl", rd, 32'h0);
    apb_read(OFF_STATUS); chk("mid_rst_status", rd, 32'h0);
    apb_read(OFF_PERIOD); chk("mid_rst_period", rd, 32'h0);
    apb_read(OFF_HIGH);   chk("mid_rst_high", rd, 32'h0);

    // Unused CTRL bits read 0; 8-bit instance: 10/20 capture, then 300 high
    apb_write(OFF_CTRL, 32'hFFFF_FFFF);
    apb_read(OFF_CTRL);   chk("ctrl_unused_bits", rd, 32'h3);
    step(2);
    cap_in8 = 1'b1; step(10);
    cap_in8 = 1'b0; step(20);
    cap_in8 = 1'b1; step(3);
    apb_read(OFF_STATUS); chk("w8_status", rd8, 32'h1);
    apb_read(OFF_PERIOD); chk("w8_period", rd8, 32'd30);
    apb_read(OFF_HIGH);   chk("w8_high", rd8, 32'd10);
    step(297);
    apb_read(OFF_STATUS); chk("ovf_status", rd8, 32'h5);
    apb_read(OFF_PERIOD); chk("ovf_period_kept", rd8, 32'd30);
    apb_read(OFF_HIGH);   chk("ovf_high_kept", rd8, 32'd10);
    chk("ovf_state", 32'(u_dut8.state_q), 32'(ST_IDLE));
    chk("ovf_cnt_no_wrap", 32'(u_dut8.cnt_q), 32'hFF);
    chk("ovf_int", 32'(cap_int8), 32'h1);
    cap_in8 = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_capture_timer.md
APB_CAPTURE_TIMER -- requirements
Module: apb_capture_timer

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset: clock apb_pclk, reset apb_prstn (all state changes on the rising edge of apb_pclk).
REQ-002 Parameter: CNT_W, default 32, width of the capture counter and the PERIOD/HIGH registers.
REQ-003 Ports SHALL be:
- apb_pclk  in  1  system clock (clk_ext8m domain).
- apb_prstn  in  1  synchronous active-low reset.
- apb_psel  in  1  APB slave select.
- apb_paddr  in  4  byte address; bits [3:2] select the register.
- apb_pwrite  in  1  1 = write.
- apb_penable  in  1  APB access phase.
- apb_pwdata  in  32  write data.
- apb_prdata  out  32  read data.
- cap_in  in  1  asynchronous external pulse input (e.g. PWM01 loopback, tachometer).
- cap_int  out  1  level interrupt to CONFREG.

Function
REQ-004 Registers SHALL be: 0x0 CTRL (RW; bit0 EN, bit1 IE), 0x4 STATUS (bit0 VALID, bit1 OVR, bit2 OVF; W1C), 0x8 PERIOD (RO), 0xC HIGH (RO). Unused bits SHALL read 0.
- A write SHALL take effect when psel & penable & pwrite.
- apb_prdata SHALL be combinational from psel & ~pwrite & paddr[3:2], and 0 otherwise.
- There SHALL be no wait states.
REQ-005 cap_in SHALL pass through a 2-flop synchronizer plus one history flop.
- rise = s2 & ~s3; fall = ~s2 & s3.
- Latency from a cap_in transition to the edge pulse SHALL be 3 cycles.
REQ-006 The FSM SHALL have three states:
- IDLE: on rise with EN=1, go to HIGH and load cnt <= 1.
- HIGH: cnt += 1 each cycle. On fall, HIGH_REG <= cnt and go to LOW.
- LOW: cnt += 1 each cycle. On rise, PERIOD_REG <= cnt, load cnt <= 1, set VALID, and go to HIGH.
REQ-007 For an input that is high H cycles and low L cycles, PERIOD SHALL equal H+L and HIGH SHALL equal H.
REQ-008 A completed capture while VALID=1 SHALL set OVR. The new values SHALL overwrite PERIOD and HIGH.
REQ-009 If cnt reaches all-ones in HIGH or LOW, the block SHALL set OVF, leave PERIOD/HIGH unchanged, and return to IDLE. cnt SHALL never wrap.
REQ-010 A W1C write and a same-cycle hardware set of the same STATUS bit SHALL leave the bit set (set wins).
REQ-011 cap_int SHALL be registered and equal IE & (VALID | OVF), one cycle after the status change.
REQ-012 Clearing EN SHALL force IDLE and cnt <= 0 on the next cycle. PERIOD, HIGH and STATUS SHALL be retained.
REQ-013 A rise in the same cycle that EN goes 0→1 SHALL be ignored. The first capture SHALL start on a later rise.

Reset
REQ-014 On apb_prstn=0 at a clock edge, the block SHALL reset as follows:
- CTRL, STATUS, PERIOD, HIGH and cnt = 0.
- FSM = IDLE.
- Synchronizer flops = 0.
- cap_int = 0.
- apb_prdata = 0 while psel=0.
REQ-015 Reset asserted mid-measurement SHALL abandon the capture with no partial register update.

Structure
REQ-016 The register offsets (0x0/0x4/0x8/0xC), CTRL/STATUS bit indices and FSM state encodings SHALL reside in a shared package/include alongside config.v.
REQ-017 The synchronizer and edge detector SHALL be one sub-module, cap_sync_edge (inputs clk, rstn, async_in; outputs rise, fall).
REQ-018 The top-level instance SHALL occupy a spare APB slot and drive the int_o source currently tied to 1'b0 at CONFREG (vpwm_int).

Verification
REQ-019 EN=1, IE=1, cap_in 5 cycles high / 15 low, repeating -> PERIOD=20, HIGH=5, VALID=1 and cap_int=1 one cycle after VALID; W1C 0x1 to STATUS -> cap_int=0 next cycle.
REQ-020 Two captures without clearing VALID -> OVR=1, PERIOD/HIGH hold the second capture's values.
REQ-021 CNT_W=8, cap_in high for 300 cycles -> OVF=1, FSM IDLE, PERIOD/HIGH unchanged, no wrap.
REQ-022 Write STATUS=0x1 in the exact cycle a capture completes -> VALID remains 1.
REQ-023 Clear EN during HIGH, then reassert EN -> no capture from the partial pulse; the next full pulse measures correctly. Also: apb_prstn=0 mid-LOW -> all registers read 0.
REQ-024 cap_in glitch of 1 cycle high -> after sync, HIGH=1 and PERIOD=1+L; confirm the 3-cycle edge latency against a reference model.
